// File: rtl/line_pkt_reader.sv
// line_pkt_reader: pulls one camera line and frames it as a byte packet (header + pixels, MSB first).
// Define LINE_PKT_CHECKSUM_EN to append an XOR checksum byte of the pixel bytes.
module line_pkt_reader #(
    parameter int         H_ACT = 1280,
    parameter logic [7:0] MAGIC = 8'hA5
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        aquire,
    output logic        read_en,
    input  logic [15:0] cam_data,
    input  logic [10:0] cam_row,
    input  logic [4:0]  cam_id,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        line_done,
    output logic        error
);
    localparam int CW = $clog2(H_ACT);

    typedef enum logic [2:0] {
        IDLE, HDR, FETCH, CAP, HI, LO, DONE
`ifdef LINE_PKT_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    hdr_idx_q, hdr_idx_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]    seq_q, seq_d;
    logic [10:0]   row_q, row_d;
    logic [4:0]    id_q, id_d;
    logic [15:0]   pix_q, pix_d;
    logic          error_q, error_d;
    logic          last_pix, abort;
`ifdef LINE_PKT_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    assign last_pix = (32'(pix_cnt_q) == H_ACT - 1);
    assign abort    = !aquire && (state_q == HDR || state_q == FETCH || state_q == CAP ||
                                  state_q == HI || state_q == LO);
    assign error    = error_q;

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        pix_cnt_d = pix_cnt_q;
        seq_d     = seq_q;
        row_d     = row_q;
        id_d      = id_q;
        pix_d     = pix_q;
        error_d   = error_q;
`ifdef LINE_PKT_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        read_en   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        line_done = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef LINE_PKT_CHECKSUM_EN
                csum_d = 8'h00;
`endif
                if (aquire) begin
                    row_d     = cam_row;
                    id_d      = cam_id;
                    hdr_idx_d = 2'd0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_idx_q == 2'd0 ? MAGIC :
                           hdr_idx_q == 2'd1 ? {id_q, row_q[10:8]} :
                           hdr_idx_q == 2'd2 ? row_q[7:0] : seq_q;
                if (tx_ready) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    state_d   = hdr_idx_q == 2'd3 ? FETCH : HDR;
                end
            end
            FETCH: begin
                read_en = 1'b1;
                state_d = CAP;
            end
            CAP: begin
                pix_d   = cam_data;
                state_d = HI;
            end
            HI: begin
                tx_valid = 1'b1;
                tx_data  = pix_q[15:8];
                if (tx_ready) begin
                    state_d = LO;
`ifdef LINE_PKT_CHECKSUM_EN
                    csum_d  = csum_q ^ pix_q[15:8];
`endif
                end
            end
            LO: begin
                tx_valid = 1'b1;
                tx_data  = pix_q[7:0];
`ifdef LINE_PKT_CHECKSUM_EN
                if (tx_ready) begin
                    csum_d    = csum_q ^ pix_q[7:0];
                    state_d   = last_pix ? CSUM : FETCH;
                    pix_cnt_d = last_pix ? pix_cnt_q : pix_cnt_q + 1'b1;
                end
`else
                tx_last = last_pix;
                if (tx_ready) begin
                    state_d   = last_pix ? DONE : FETCH;
                    pix_cnt_d = last_pix ? pix_cnt_q : pix_cnt_q + 1'b1;
                end
`endif
            end
`ifdef LINE_PKT_CHECKSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                tx_last  = 1'b1;
                if (tx_ready) state_d = DONE;
            end
`endif
            DONE: begin
                line_done = 1'b1;
                seq_d     = seq_q + 8'd1;
                pix_cnt_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort leaves seq untouched so the retried line reuses it
        if (abort) begin
            error_d   = 1'b1;
            pix_cnt_d = '0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_idx_q <= 2'd0;
            pix_cnt_q <= '0;
            seq_q     <= 8'h00;
            row_q     <= 11'h000;
            id_q      <= 5'h00;
            pix_q     <= 16'h0000;
            error_q   <= 1'b0;
`ifdef LINE_PKT_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            pix_cnt_q <= pix_cnt_d;
            seq_q     <= seq_d;
            row_q     <= row_d;
            id_q      <= id_d;
            pix_q     <= pix_d;
            error_q   <= error_d;
`ifdef LINE_PKT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_line_pkt_reader.sv
// tb_line_pkt_reader: scoreboard bench with a packet-level reference model and randomized backpressure.
module tb_line_pkt_reader;
    localparam int H = 4;
`ifdef LINE_PKT_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        rclk = 1'b0, rst = 1'b1, aquire = 1'b0, tx_ready = 1'b0;
    logic [15:0] cam_data = 16'h0;
    logic [10:0] cam_row = 11'h0;
    logic [4:0]  cam_id = 5'h0;
    logic        read_en, tx_valid, tx_last, line_done, error;
    logic [7:0]  tx_data;

    line_pkt_reader #(.H_ACT(H), .MAGIC(8'hA5)) dut (
        .rclk(rclk), .rst(rst), .aquire(aquire), .read_en(read_en), .cam_data(cam_data),
        .cam_row(cam_row), .cam_id(cam_id), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .line_done(line_done), .error(error)
    );

    always #5 rclk = ~rclk;

    int          tests = 0, fails = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] pix_src[$];
    int          acc_cnt = 0, ld_cnt = 0, ld_exp = 0, rd_cnt = 0, rcyc = 0, ready_mode = 0;
    logic [7:0]  seq_m = 8'h00;
    bit          ready_hold = 1'b0, prev_stall = 1'b0, prev_rd = 1'b0;
    logic [8:0]  prev_byte = 9'h0;

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", n, got, want);
        end
    endtask

    // Monitor: pixel source, read discipline, stall stability and byte scoreboard
    initial forever begin
        @(negedge rclk);
        if (rst) begin
            prev_stall = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            if (read_en) begin
                rd_cnt++;
                check("rd_consec", 32'(prev_rd), 32'd0);
                check("rd_extra", 32'(pix_src.size() > 0), 32'd1);
                if (pix_src.size() > 0) cam_data = pix_src.pop_front();
            end
            prev_rd = read_en;
            if (prev_stall && aquire) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_hold", 32'({tx_last, tx_data}), 32'(prev_byte));
            end
            if (tx_valid && tx_ready) begin
                acc_cnt++;
                check("byte_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("byte", 32'({tx_last, tx_data}), 32'(exp_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = {tx_last, tx_data};
            if (line_done) ld_cnt++;
        end
    end

    initial forever begin
        @(posedge rclk);
        #1;
        rcyc++;
        if (!ready_hold)
            tx_ready = ready_mode == 0 ? 1'b1 :
                       ready_mode == 1 ? (rcyc % 4 == 0 || rcyc % 4 == 3) :
                       1'($urandom_range(0, 1));
    end

    task automatic start_line(input bit fixed, input int keep);
        logic [8:0]  pk[$];
        logic [15:0] p;
        logic [7:0]  cs;
        cs      = 8'h00;
        cam_row = fixed ? 11'h123 : 11'($urandom);
        cam_id  = fixed ? 5'b10000 : 5'(1 << $urandom_range(0, 4));
        pk.push_back({1'b0, 8'hA5});
        pk.push_back({1'b0, cam_id, cam_row[10:8]});
        pk.push_back({1'b0, cam_row[7:0]});
        pk.push_back({1'b0, seq_m});
        for (int i = 0; i < H; i++) begin
            p = fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
            pix_src.push_back(p);
            pk.push_back({1'b0, p[15:8]});
            pk.push_back({(i == H - 1) && !CS, p[7:0]});
            cs = cs ^ p[15:8] ^ p[7:0];
        end
        if (CS) pk.push_back({1'b1, cs});
        for (int i = 0; i < keep && i < pk.size(); i++) exp_q.push_back(pk[i]);
        rd_cnt = 0;
        aquire = 1'b1;
    endtask

    task automatic wait_done(input string n);
        int c;
        for (c = 0; c < 400; c++) begin
            @(posedge rclk);
            #1;
            if (line_done) break;
        end
        check(n, 32'(c < 400), 32'd1);
        seq_m = seq_m + 8'd1;
        ld_exp++;
        @(negedge rclk);
        #1;
        check("rd_count", 32'(rd_cnt), 32'(H));
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        check("line_done_cnt", 32'(ld_cnt), 32'(ld_exp));
    endtask

    task automatic wait_acc(input int target);
        int c;
        for (c = 0; c < 400 && acc_cnt != target; c++) begin
            @(posedge rclk);
            #1;
        end
        check("acc_wait", 32'(acc_cnt), 32'(target));
    endtask

    initial begin
        #1;
        check("reset_outs", 32'({read_en, tx_valid, tx_last, line_done, error, tx_data}), 32'd0);
        repeat (2) @(negedge rclk);
        rst = 1'b0;
        @(posedge rclk);
        #1;
        ready_mode = 0;
        start_line(1'b1, 99);
        wait_done("basic");
        ready_mode = 1;
        start_line(1'b1, 99);
        wait_done("backpressure");
        for (int k = 0; k < 257; k++) begin
            ready_mode = k % 3;
            start_line(1'b0, 99);
            wait_done("seq_wrap");
        end
        ready_mode = 0;
        @(posedge rclk);
        #1;
        start_line(1'b0, 7);
        wait_acc(acc_cnt + 7);
        ready_hold = 1'b1;
        tx_ready   = 1'b0;
        aquire     = 1'b0;
        repeat (2) begin
            @(posedge rclk);
            #1;
        end
        check("abort_error", 32'(error), 32'd1);
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_bytes", 32'(exp_q.size()), 32'd0);
        check("abort_reads", 32'(rd_cnt), 32'd2);
        check("abort_no_done", 32'(ld_cnt), 32'(ld_exp));
        pix_src.delete();
        ready_hold = 1'b0;
        @(posedge rclk);
        #1;
        start_line(1'b0, 99);
        wait_done("after_abort");
        check("error_sticky", 32'(error), 32'd1);
        start_line(1'b0, 5);
        wait_acc(acc_cnt + 5);
        rst = 1'b1;
        #1;
        check("rst_async", 32'({read_en, tx_valid, tx_last, line_done, error, tx_data}), 32'd0);
        check("rst_bytes", 32'(exp_q.size()), 32'd0);
        aquire = 1'b0;
        exp_q.delete();
        pix_src.delete();
        seq_m = 8'h00;
        repeat (2) @(negedge rclk);
        rst = 1'b0;
        @(posedge rclk);
        #1;
        ready_mode = 2;
        start_line(1'b0, 99);
        wait_done("after_reset");
        aquire = 1'b0;
        repeat (5) @(posedge rclk);
        #1;
        check("final_bytes", 32'(exp_q.size()), 32'd0);
        check("final_done_cnt", 32'(ld_cnt), 32'(ld_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
